// File: rtl/simon_serial_param.sv
// Parametrised bit-serial SIMON encryption block.
// Serial load, one round per cycle, framed serial ciphertext unload.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   data_in    - serial load bit
//   data_rdy   - 0 idle, 1 load plaintext, 2 load key, 3 run
//   cipher_out - serial ciphertext bit, LSB first (valid with out_valid)
//   out_valid  - cipher_out carries a ciphertext bit this cycle
//   busy       - high while running rounds or unloading
//   done       - high once the full ciphertext has been unloaded
module simon_serial_param #(
    parameter int          N    = 64,
    parameter int          M    = 2,
    parameter int          T    = 68,
    parameter logic [61:0] ZSEQ =
        62'b10101111011100000011010010011000101000010001111110010110110011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] data_rdy,
    output logic       cipher_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam int BW  = 2 * N;
    localparam int KW  = M * N;
    localparam int RW  = $clog2(T + 1);
    localparam int PW  = $clog2(BW + 1);
    localparam int KCW = $clog2(KW + 1);
    localparam int UW  = $clog2(BW);

    localparam logic [PW-1:0]  PT_FULL  = PW'(BW);
    localparam logic [PW-1:0]  PT_LAST  = PW'(BW - 1);
    localparam logic [KCW-1:0] KEY_FULL = KCW'(KW);
    localparam logic [KCW-1:0] KEY_LAST = KCW'(KW - 1);
    localparam logic [RW-1:0]  R_LAST   = RW'(T - 1);
    localparam logic [UW-1:0]  U_LAST   = UW'(BW - 1);

    localparam logic [1:0] MODE_PT  = 2'd1;
    localparam logic [1:0] MODE_KEY = 2'd2;
    localparam logic [1:0] MODE_RUN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   blk;
    logic [KW-1:0]   key;
    logic [PW-1:0]   pt_cnt;
    logic [KCW-1:0]  key_cnt;
    logic            pt_ok;
    logic            key_ok;
    logic [RW-1:0]   rnd;
    logic [UW-1:0]   ucnt;

    logic [N-1:0]    x;
    logic [N-1:0]    y;
    logic [N-1:0]    k0;
    logic [N-1:0]    k1;
    logic [N-1:0]    kl;
    logic [N-1:0]    fx;
    logic [N-1:0]    tmp;
    logic [N-1:0]    knew;
    logic [5:0]      zidx;
    logic            zbit;
    logic [BW-1:0]   round_blk;
    logic [KW-1:0]   next_key;

    function automatic logic [N-1:0] rol(
        input logic [N-1:0] v,
        input int           s
    );
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(
        input logic [N-1:0] v,
        input int           s
    );
        return (v >> s) | (v << (N - s));
    endfunction

    // Round function and key-schedule step for the current round.
    always_comb begin
        x    = blk[BW-1:N];
        y    = blk[N-1:0];
        k0   = key[N-1:0];
        k1   = key[2*N-1:N];
        kl   = key[KW-1:KW-N];
        fx   = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);

        round_blk = {y ^ fx ^ k0, x};

        // Round constant: leftmost ZSEQ bit belongs to round 0.
        zidx = 6'(61 - (int'(rnd) % 62));
        zbit = ZSEQ[zidx];

        tmp = ror(kl, 3);
        if (M == 4) begin
            tmp = tmp ^ k1;
        end
        tmp  = tmp ^ ror(tmp, 1);
        knew = ~k0 ^ tmp ^ N'(3) ^ {{(N-1){1'b0}}, zbit};

        // Key window slides down one word; new word enters on top.
        next_key = {knew, key[KW-1:N]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            blk       <= '0;
            key       <= '0;
            pt_cnt    <= '0;
            key_cnt   <= '0;
            pt_ok     <= 1'b0;
            key_ok    <= 1'b0;
            rnd       <= '0;
            ucnt      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    unique case (data_rdy)
                        MODE_PT: begin
                            blk <= {data_in, blk[BW-1:1]};
                            if (pt_cnt != PT_FULL) begin
                                pt_cnt <= pt_cnt + 1'b1;
                            end
                            if (pt_cnt == PT_LAST) begin
                                pt_ok <= 1'b1;
                            end
                        end
                        MODE_KEY: begin
                            key <= {data_in, key[KW-1:1]};
                            if (key_cnt != KEY_FULL) begin
                                key_cnt <= key_cnt + 1'b1;
                            end
                            if (key_cnt == KEY_LAST) begin
                                key_ok <= 1'b1;
                            end
                        end
                        MODE_RUN: begin
                            // Starting consumes both loads; a new run
                            // needs fresh plaintext and key.
                            if (pt_ok && key_ok) begin
                                state   <= S_RUN;
                                busy    <= 1'b1;
                                rnd     <= '0;
                                pt_ok   <= 1'b0;
                                key_ok  <= 1'b0;
                                pt_cnt  <= '0;
                                key_cnt <= '0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                S_RUN: begin
                    if (data_rdy != MODE_RUN) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        blk <= round_blk;
                        key <= next_key;
                        if (rnd == R_LAST) begin
                            state     <= S_UNLOAD;
                            out_valid <= 1'b1;
                            ucnt      <= '0;
                        end else begin
                            rnd <= rnd + 1'b1;
                        end
                    end
                end

                S_UNLOAD: begin
                    if (data_rdy != MODE_RUN) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else begin
                        // Bit 0 always drives cipher_out.
                        blk <= {1'b0, blk[BW-1:1]};
                        if (ucnt == U_LAST) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            ucnt <= ucnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (data_rdy != MODE_RUN) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cipher_out = out_valid & blk[0];

endmodule

// File: tb/tb_simon_serial_param.sv
// Self-checking bench for simon_serial_param.
// Scoreboard queues hold expected cipher bits; monitors pop on out_valid.
module tb_simon_serial_param;

    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [127:0] PT128  = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] KEY128 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT128  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
    localparam logic [31:0]  PT32   = 32'h65656877;
    localparam logic [63:0]  KEY64  = 64'h1918111009080100;
    localparam logic [31:0]  CT32   = 32'hc69be9bb;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic [1:0] data_rdy;
    logic       cipher_out;
    logic       out_valid;
    logic       busy;
    logic       done;

    logic       di16;
    logic [1:0] dr16;
    logic       co16;
    logic       ov16;
    logic       busy16;
    logic       done16;

    int n_chk  = 0;
    int n_pass = 0;
    bit q[$];
    bit q16[$];

    always #5 clk = ~clk;

    simon_serial_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_rdy   (data_rdy),
        .cipher_out (cipher_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    simon_serial_param #(
        .N    (16),
        .M    (4),
        .T    (32),
        .ZSEQ (Z0)
    ) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (di16),
        .data_rdy   (dr16),
        .cipher_out (co16),
        .out_valid  (ov16),
        .busy       (busy16),
        .done       (done16)
    );

    task automatic check(
        input string        name,
        input logic [127:0] act,
        input logic [127:0] exp
    );
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                check("cipher_bit", cipher_out, q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (ov16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("spurious_valid16", ov16, 1'b0);
            end else begin
                check("cipher_bit16", co16, q16.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(
        input logic [1:0]   mode,
        input logic [127:0] v,
        input int           nbits
    );
        data_rdy = mode;
        for (int i = 0; i < nbits; i++) begin
            data_in = v[i];
            tick();
        end
        data_rdy = 2'd0;
        data_in  = 1'b0;
    endtask

    task automatic run_expect(
        input logic [127:0] ct,
        input string        tag
    );
        int lat;
        bit seen;
        for (int b = 0; b < 128; b++) begin
            q.push_back(ct[b]);
        end
        data_rdy = 2'd3;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, 69);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_busy_in_done"}, busy, 1'b0);
        check({tag, "_sb_empty"}, q.size(), 0);
        data_rdy = 2'd0;
        tick();
        check({tag, "_done_clear"}, done, 1'b0);
        q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  nb;
        int  lat;
        bit  seen;

        rst      = 1'b1;
        data_in  = 1'b0;
        data_rdy = 2'd0;
        di16     = 1'b0;
        dr16     = 2'd0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cipher_out", cipher_out, 1'b0);
        check("rst16_outputs", {ov16, busy16, done16, co16}, 4'b0);
        rst = 1'b0;
        tick();

        // Simon128/128 reference vector.
        send(2'd1, PT128, 128);
        send(2'd2, KEY128, 128);
        run_expect(CT128, "t1");

        // Simon32/64 reference vector on the small instance.
        dr16 = 2'd1;
        for (int i = 0; i < 32; i++) begin
            di16 = PT32[i];
            tick();
        end
        dr16 = 2'd2;
        for (int i = 0; i < 64; i++) begin
            di16 = KEY64[i];
            tick();
        end
        for (int b = 0; b < 32; b++) begin
            q16.push_back(CT32[b]);
        end
        dr16 = 2'd3;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            lat++;
            if (ov16) seen = 1'b1;
        end
        check("t2_latency", lat, 33);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (done16) seen = 1'b1;
        end
        check("t2_done", seen, 1'b1);
        check("t2_sb_empty", q16.size(), 0);
        dr16 = 2'd0;
        tick();
        check("t2_done_clear", done16, 1'b0);

        // Run without a key: must never start.
        send(2'd1, PT128, 128);
        data_rdy = 2'd3;
        nb = 0;
        repeat (200) begin
            tick();
            if (busy || out_valid) nb++;
        end
        check("t3_no_key_busy", nb, 0);
        data_rdy = 2'd0;
        tick();
        send(2'd2, KEY128, 128);
        run_expect(CT128, "t3");

        // Abort at round 30, then reload and rerun.
        send(2'd1, PT128, 128);
        send(2'd2, KEY128, 128);
        data_rdy = 2'd3;
        tick();
        repeat (30) tick();
        check("t4_busy_running", busy, 1'b1);
        data_rdy = 2'd0;
        tick();
        check("t4_abort_busy", busy, 1'b0);
        check("t4_abort_valid", out_valid, 1'b0);
        tick();
        send(2'd1, PT128, 128);
        send(2'd2, KEY128, 128);
        run_expect(CT128, "t4");

        // Two junk bits ahead of the plaintext are pushed out.
        send(2'd1, 128'h3, 2);
        send(2'd1, PT128, 128);
        send(2'd2, KEY128, 128);
        run_expect(CT128, "t5");

        // Reset in the middle of unload.
        send(2'd1, PT128, 128);
        send(2'd2, KEY128, 128);
        for (int b = 0; b < 128; b++) begin
            q.push_back(CT128[b]);
        end
        data_rdy = 2'd3;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("t6_reach_unload", seen, 1'b1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_outputs",
              {out_valid, busy, done, cipher_out}, 4'b0);
        q.delete();
        rst = 1'b0;
        nb = 0;
        repeat (20) begin
            tick();
            if (busy || out_valid || done) nb++;
        end
        check("t6_no_reload_idle", nb, 0);
        data_rdy = 2'd0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
